// File: rtl/multi_cycle_control.sv
// multi_cycle_control
//   Control unit for a multi-cycle RISC-style datapath. A single FSM steps
//   each instruction through FETCH / DECODE / address / memory / write-back
//   phases and drives the datapath mux selects and write enables.
//
// Ports
//   clk, rst_n      clock (rising edge), async active-low reset
//   opcode[6:0]     instruction opcode, looked at in DECODE and MEMADR only
//   mem_ready       memory handshake, looked at in FETCH/MEMREAD/MEMWRITE only
//   pc_write, pc_write_cond, pc_source      PC update controls
//   i_or_d, mem_read, mem_write, ir_write   memory / IR controls
//   mem_to_reg, reg_write                   register file write-back
//   alu_src_a[1:0], alu_src_b[1:0], alu_op[1:0]  ALU operand / op selects
//   state[3:0]      current state (debug)
//   retire          last cycle of an instruction
//   illegal         unsupported opcode seen in DECODE
module multi_cycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [3:0] state,
  output logic       retire,
  output logic       illegal
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_RWB      = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [3:0] state_q, state_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTE;
          OP_BRANCH:         state_d = S_BRANCH;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECUTE:  state_d = S_RWB;
      S_RWB:      state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Output logic. Gated by rst_n so every output (including the FETCH
  // defaults) is low for the whole time reset is held, not just after
  // the next edge.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    retire        = 1'b0;
    illegal       = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          // IR and PC load only on the cycle the fetch completes
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b10;
          if (!(opcode inside {OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH})) begin
            illegal = 1'b1;
            retire  = 1'b1;
          end
        end
        S_MEMADR: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
        end
        S_MEMREAD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          retire     = 1'b1;
        end
        S_MEMWRITE: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          retire    = mem_ready;
        end
        S_EXECUTE: begin
          alu_src_a = 2'b01;
          alu_op    = 2'b10;
        end
        S_RWB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 2'b01;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 1'b1;
          retire        = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
module tb_multi_cycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_write, retire, illegal;
  logic [1:0] alu_src_a, alu_src_b, alu_op;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;
  int ret_cnt = 0;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] BEQ = 7'b1100011;

  always #5 clk = ~clk;

  multi_cycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .state(state), .retire(retire), .illegal(illegal)
  );

  logic [16:0] outv;
  assign outv = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                 ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                 retire, illegal};

  // Expected control word for a state, written straight from the per-state
  // output list of the block description.
  function automatic logic [16:0] exp_out(int st, logic [6:0] op, logic mr);
    logic pw, pwc, ps, iod, mrd, mwr, irw, m2r, rw, ret, ill;
    logic [1:0] a, b, ao;
    {pw, pwc, ps, iod, mrd, mwr, irw, m2r, rw, ret, ill} = '0;
    a = 2'b00; b = 2'b00; ao = 2'b00;
    case (st)
      0: begin mrd = 1; b = 2'b01; irw = mr; pw = mr; end
      1: begin
        a = 2'b10; b = 2'b10;
        if (!(op == LW || op == SW || op == RT || op == BEQ)) begin ill = 1; ret = 1; end
      end
      2: begin a = 2'b01; b = 2'b10; end
      3: begin mrd = 1; iod = 1; end
      4: begin rw = 1; m2r = 1; ret = 1; end
      5: begin mwr = 1; iod = 1; ret = mr; end
      6: begin a = 2'b01; ao = 2'b10; end
      7: begin rw = 1; ret = 1; end
      8: begin a = 2'b01; ao = 2'b01; pwc = 1; ps = 1; ret = 1; end
      default: ;
    endcase
    return {pw, pwc, ps, iod, mrd, mwr, irw, m2r, rw, a, b, ao, ret, ill};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", nm, got, exp, $time);
    end
  endtask

  // One clock cycle: entered just after a rising edge, drives inputs,
  // checks state and outputs at the falling edge, returns after next edge.
  task automatic cyc(input logic [6:0] op, input logic mr, input int exp_st, input string nm);
    opcode = op;
    mem_ready = mr;
    @(negedge clk);
    chk({nm, ".state"}, {28'd0, state}, exp_st);
    chk({nm, ".outs"}, {15'd0, outv}, {15'd0, exp_out(exp_st, op, mr)});
    if (retire) ret_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("reset.outs", {15'd0, outv}, 32'd0);
    chk("reset.state", {28'd0, state}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("reset.hold", {15'd0, outv}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset.first_state", {28'd0, state}, 32'd0);
    chk("reset.first_memread", {31'd0, mem_read}, 32'd1);
  endtask

  typedef struct {
    string      name;
    logic [6:0] op;
    int         len;
    int         seq[6];
  } vec_t;

  vec_t vt[6];

  initial begin
    vt[0].name = "rtype";   vt[0].op = RT;       vt[0].len = 4; vt[0].seq = '{0, 1, 6, 7, 0, 0};
    vt[1].name = "load";    vt[1].op = LW;       vt[1].len = 5; vt[1].seq = '{0, 1, 2, 3, 4, 0};
    vt[2].name = "store";   vt[2].op = SW;       vt[2].len = 4; vt[2].seq = '{0, 1, 2, 5, 0, 0};
    vt[3].name = "beq";     vt[3].op = BEQ;      vt[3].len = 3; vt[3].seq = '{0, 1, 8, 0, 0, 0};
    vt[4].name = "ill_ff";  vt[4].op = 7'h7f;    vt[4].len = 2; vt[4].seq = '{0, 1, 0, 0, 0, 0};
    vt[5].name = "ill_00";  vt[5].op = 7'h00;    vt[5].len = 2; vt[5].seq = '{0, 1, 0, 0, 0, 0};

    do_reset();

    // Table: mem_ready held high, each instruction's state path and one retire
    foreach (vt[i]) begin
      ret_cnt = 0;
      for (int c = 0; c < vt[i].len; c++) cyc(vt[i].op, 1'b1, vt[i].seq[c], vt[i].name);
      chk({vt[i].name, ".retires"}, ret_cnt, 1);
    end
    cyc(RT, 1'b0, 0, "table_end");

    // Load with two wait cycles in MEMREAD: 0,1,2,3,3,3,4,0
    ret_cnt = 0;
    cyc(LW, 1, 0, "lw_wait"); cyc(LW, 1, 1, "lw_wait"); cyc(LW, 1, 2, "lw_wait");
    cyc(LW, 0, 3, "lw_wait"); cyc(LW, 0, 3, "lw_wait"); cyc(LW, 1, 3, "lw_wait");
    cyc(LW, 1, 4, "lw_wait");
    chk("lw_wait.retires", ret_cnt, 1);

    // Fetch stall 3 cycles, then R-type completes
    ret_cnt = 0;
    for (int k = 0; k < 3; k++) cyc(RT, 0, 0, "fetch_stall");
    cyc(RT, 1, 0, "fetch_go"); cyc(RT, 0, 1, "fetch_go");
    cyc(RT, 0, 6, "fetch_go"); cyc(RT, 0, 7, "fetch_go");
    chk("fetch_stall.retires", ret_cnt, 1);

    // Reset pulse in the middle of a stalled MEMWRITE
    ret_cnt = 0;
    cyc(SW, 1, 0, "sw_rst"); cyc(SW, 1, 1, "sw_rst"); cyc(SW, 1, 2, "sw_rst");
    opcode = SW; mem_ready = 1'b0;
    #2;
    chk("sw_rst.in_memwrite", {28'd0, state}, 32'd5);
    chk("sw_rst.mem_write_hi", {31'd0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("sw_rst.mem_write_drop", {31'd0, mem_write}, 32'd0);
    chk("sw_rst.state_zero", {28'd0, state}, 32'd0);
    chk("sw_rst.all_zero", {15'd0, outv}, 32'd0);
    @(posedge clk); #1;
    chk("sw_rst.still_zero", {15'd0, outv}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("sw_rst.retires", ret_cnt + {31'd0, retire}, 0);
    cyc(SW, 0, 0, "after_rst");

    // Randomized instruction stream against a plan-per-instruction model.
    // Opcode is scrambled outside DECODE/MEMADR to show it is ignored there.
    for (int n = 0; n < 400; n++) begin
      int plan[$];
      int idx;
      int k;
      logic [6:0] op;
      logic mr;
      logic [6:0] drv;
      k = $urandom_range(0, 4);
      case (k)
        0: begin op = LW;  plan = '{0, 1, 2, 3, 4}; end
        1: begin op = SW;  plan = '{0, 1, 2, 5}; end
        2: begin op = RT;  plan = '{0, 1, 6, 7}; end
        3: begin op = BEQ; plan = '{0, 1, 8}; end
        default: begin
          op = 7'($urandom);
          while (op == LW || op == SW || op == RT || op == BEQ) op = 7'($urandom);
          plan = '{0, 1};
        end
      endcase
      ret_cnt = 0;
      idx = 0;
      while (idx < plan.size()) begin
        int st;
        st = plan[idx];
        mr = ($urandom_range(0, 3) != 0);
        drv = (st == 1 || st == 2) ? op : 7'($urandom);
        cyc(drv, mr, st, "rand");
        if ((st == 0 || st == 3 || st == 5) && !mr) ; else idx++;
      end
      chk("rand.retires", ret_cnt, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1);
  end

endmodule
